// File: rtl/toki_palette_ram_pkg.sv
// Shared video constants for the palette RAM: layer offsets, xBGR444 field
// positions, CPU access FSM states and the posted-write payload.
package toki_palette_ram_pkg;

  localparam logic [9:0] PAL_CHAR_OFS    = 10'h100;
  localparam logic [9:0] PAL_BG1_OFS     = 10'h200;
  localparam logic [9:0] PAL_BG2_OFS     = 10'h300;
  localparam logic [9:0] PAL_TRANSPARENT = 10'h3FF;

  localparam int PAL_R_LSB   = 0;
  localparam int PAL_G_LSB   = 4;
  localparam int PAL_B_LSB   = 8;
  localparam int PAL_FIELD_W = 4;

  typedef enum logic [2:0] {
    CPU_IDLE,
    CPU_WR_PUSH,
    CPU_RD_WAIT,
    CPU_RD_ISSUE,
    CPU_RD_DATA,
    CPU_ACK
  } cpu_state_t;

  typedef struct packed {
    logic [9:0]  addr;
    logic [1:0]  ds;
    logic [15:0] data;
  } pal_wr_t;

  function automatic logic [15:0] pal_color(input logic [3:0] b, input logic [3:0] g,
                                            input logic [3:0] r);
    logic [15:0] c;
    c = '0;
    c[PAL_B_LSB +: PAL_FIELD_W] = b;
    c[PAL_G_LSB +: PAL_FIELD_W] = g;
    c[PAL_R_LSB +: PAL_FIELD_W] = r;
    return c;
  endfunction

endpackage

// File: rtl/toki_palette_ram_if.sv
// CPU-side bus of the palette RAM (68000-style strobe/ack handshake).
interface toki_palette_ram_if;
  logic        cs;
  logic        we;
  logic [1:0]  ds;
  logic [10:1] addr;
  logic [15:0] din;
  logic [15:0] dout;
  logic        ack;

  modport master (output cs, we, ds, addr, din, input dout, ack);
  modport slave  (input cs, we, ds, addr, din, output dout, ack);
endinterface

// File: rtl/palette_wr_fifo.sv
// Posted-write buffer for CPU palette writes; power-of-two depth so the
// pointers wrap for free.
module palette_wr_fifo
  import toki_palette_ram_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  pal_wr_t wr_data,
  input  logic    pop,
  output pal_wr_t rd_data,
  output logic    full,
  output logic    empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = DEPTH[CNT_W-1:0];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;
  pal_wr_t          entries [DEPTH];

  always_comb begin
    full     = (count_q == FULL_COUNT);
    empty    = (count_q == '0);
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    // Push and pop in the same cycle cancel out in the count.
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    rd_data  = entries[rd_ptr_q];
  end

  always_ff @(posedge clk) begin
    if (do_push) entries[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/toki_palette_ram.sv
// 1024x16 palette RAM shared between the colour mixer (priority on pxl_cen)
// and the CPU, whose writes are posted through a small FIFO.
module toki_palette_ram
  import toki_palette_ram_pkg::*;
#(
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [15:0] BLANK_COLOR = 16'h0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pxl_cen,
  input  logic               display_on,
  input  logic [10:1]        vid_addr,
  output logic [15:0]        vid_data,
  toki_palette_ram_if.slave  cpu,
  output logic               fifo_full
);
  cpu_state_t  state_q, state_d;
  logic        vid_sel_q, vid_sel_d, disp_q, disp_d;
  logic [15:0] vid_hold_q, vid_hold_d, dout_q, dout_d;
  logic [15:0] cpu_dout;
  logic        fifo_empty, push, drain, rd_slot, ram_en;
  pal_wr_t     push_entry, head;
  logic [9:0]  ram_addr;
  logic [1:0]  ram_we;
  logic [15:0] ram [1024];
  logic [15:0] ram_rdata;

  palette_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_wr_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data (push_entry),
    .pop     (drain),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign push_entry = '{addr: cpu.addr, ds: cpu.ds, data: cpu.din};

  // One RAM access per clk: video, then FIFO drain, then CPU read.
  always_comb begin
    drain    = !pxl_cen && !fifo_empty;
    rd_slot  = !pxl_cen && fifo_empty && (state_q == CPU_RD_ISSUE);
    ram_en   = pxl_cen || rd_slot;
    ram_we   = drain ? head.ds : 2'b00;
    ram_addr = cpu.addr;
    if (pxl_cen)    ram_addr = vid_addr;
    else if (drain) ram_addr = head.addr;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (ram_we[i]) ram[ram_addr][i*8 +: 8] <= head.data[i*8 +: 8];
    end
    if (ram_en) ram_rdata <= ram[ram_addr];
  end

  // Outputs follow the RAM register only in the cycle after their slot, then hold.
  always_comb begin
    vid_sel_d = pxl_cen;
    disp_d    = display_on;
    vid_data  = vid_hold_q;
    if (vid_sel_q) vid_data = disp_q ? ram_rdata : BLANK_COLOR;
    vid_hold_d = vid_data;
    cpu_dout   = (state_q == CPU_RD_DATA) ? ram_rdata : dout_q;
    dout_d     = cpu_dout;
  end

  assign cpu.dout = cpu_dout;
  assign cpu.ack  = (state_q == CPU_RD_DATA) || (state_q == CPU_ACK);

  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    case (state_q)
      CPU_IDLE: begin
        if (cpu.cs) begin
          if (!cpu.we) begin
            state_d = CPU_RD_WAIT;
          end else if (cpu.ds == 2'b00) begin
            state_d = CPU_ACK;
          end else if (!fifo_full) begin
            push    = 1'b1;
            state_d = CPU_ACK;
          end else begin
            state_d = CPU_WR_PUSH;
          end
        end
      end
      CPU_WR_PUSH: begin
        if (!cpu.cs) begin
          state_d = CPU_IDLE;
        end else if (!fifo_full) begin
          push    = 1'b1;
          state_d = CPU_ACK;
        end
      end
      CPU_RD_WAIT: begin
        if (!cpu.cs)         state_d = CPU_IDLE;
        else if (fifo_empty) state_d = CPU_RD_ISSUE;
      end
      CPU_RD_ISSUE: begin
        if (!cpu.cs)      state_d = CPU_IDLE;
        else if (rd_slot) state_d = CPU_RD_DATA;
      end
      CPU_RD_DATA: state_d = cpu.cs ? CPU_ACK : CPU_IDLE;
      CPU_ACK:     if (!cpu.cs) state_d = CPU_IDLE;
      default:     state_d = CPU_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= CPU_IDLE;
      vid_sel_q  <= 1'b0;
      disp_q     <= 1'b0;
      vid_hold_q <= BLANK_COLOR;
      dout_q     <= '0;
    end else begin
      state_q    <= state_d;
      vid_sel_q  <= vid_sel_d;
      disp_q     <= disp_d;
      vid_hold_q <= vid_hold_d;
      dout_q     <= dout_d;
    end
  end

endmodule
